xgmii_tx_framer: RTL and testbench

Packet-to-XGMII transmit framer that sits directly upstream of the XAUI core and drives its 64-bit `xgmii_txd`/`xgmii_txc` inputs on `usrclk`. It accepts a word-wide packet stream with valid/ready handshaking, emits Start/preamble/SFD, payload, optional FCS, Terminate and a minimum inter-frame gap of Idles. It flags mid-packet underruns with /E/ characters.

---
 rtl/xgmii_pkg.sv | 34 +++
 rtl/crc32_d64.sv | 32 +++
 rtl/xgmii_tx_framer.sv | 167 ++++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII characters, framer state encoding and CRC-32 constants for the
// transmit framer and its CRC helper.
package xgmii_pkg;

  localparam logic [7:0] CH_IDLE     = 8'h07;
  localparam logic [7:0] CH_START    = 8'hFB;
  localparam logic [7:0] CH_TERM     = 8'hFD;
  localparam logic [7:0] CH_ERROR    = 8'hFE;
  localparam logic [7:0] CH_PREAMBLE = 8'h55;
  localparam logic [7:0] CH_SFD      = 8'hD5;

  localparam logic [63:0] IDLE_WORD  = {8{CH_IDLE}};
  localparam logic [63:0] ERROR_WORD = {8{CH_ERROR}};
  localparam logic [63:0] START_WORD = {CH_SFD, {6{CH_PREAMBLE}}, CH_START};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_TAIL,
    S_DROP,
    S_IFG
  } state_t;

  // Reflected IEEE 802.3 polynomial, processed LSB first.
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Final-word byte count: 0 encodes a full 8-byte word.
  function automatic logic [3:0] byte_count(input logic [2:0] b);
    return (b == 3'd0) ? 4'd8 : {1'b0, b};
  endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational CRC-32 update over the first nbytes lanes (0 means 8) of a
// 64-bit word, lane 0 first, bits LSB first.
module crc32_d64
  import xgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] crc_out
);

  logic [3:0]  n;
  logic [31:0] c;
  logic        fb;

  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    n  = byte_count(nbytes);
    c  = crc_in;
    fb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(n)) begin
        for (int i = 0; i < 8; i++) begin
          fb = c[0] ^ data[8*k+i];
          c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY : 32'h0);
        end
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/xgmii_tx_framer.sv
// Packet stream to 64-bit XGMII transmit framer with underrun signalling.
// Define XGMII_TX_FCS_EN to append a CRC-32 FCS to every frame.
module xgmii_tx_framer
  import xgmii_pkg::*;
#(
  parameter int IFG_WORDS = 2
) (
  input  logic        usrclk,
  input  logic        reset,
  input  logic [63:0] tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  input  logic [2:0]  tx_bytes,
  output logic        tx_ready,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        tx_underrun,
  output logic [31:0] frame_count
);

  state_t       state;
  logic [3:0]   ifg_cnt;
  logic [63:0]  tail_d;
  logic [7:0]   tail_c;
  logic [3:0]   n_last;
  logic [4:0]   term_pos;
  logic [127:0] data_ext;
  logic [127:0] fin_d;
  logic [15:0]  fin_c;

  assign tx_ready = (state == S_DATA) || (state == S_DROP);
  assign n_last   = byte_count(tx_bytes);
  assign data_ext = {64'h0, tx_data};

`ifdef XGMII_TX_FCS_EN
  logic [31:0] crc_q;
  logic [31:0] crc_next;
  logic [31:0] fcs;
  logic [1:0]  fcs_sel;

  crc32_d64 u_crc (
    .crc_in  (crc_q),
    .data    (tx_data),
    .nbytes  (tx_last ? tx_bytes : 3'd0),
    .crc_out (crc_next)
  );

  assign fcs      = ~crc_next;
  assign term_pos = {1'b0, n_last} + 5'd4;
`else
  assign term_pos = {1'b0, n_last};
`endif

  // Final word and its overflow laid out as one 16-lane stream: payload,
  // FCS, Terminate, Idle. Lanes 8..15 feed the TAIL word when needed.
  always_comb begin
    fin_d = {2{IDLE_WORD}};
    fin_c = '1;
`ifdef XGMII_TX_FCS_EN
    fcs_sel = 2'd0;
`endif
    for (int k = 0; k < 16; k++) begin
      fin_c[k] = (k >= int'(term_pos));
      if (k < int'(n_last)) begin
        fin_d[8*k +: 8] = data_ext[8*k +: 8];
      end
`ifdef XGMII_TX_FCS_EN
      else if (k < int'(term_pos)) begin
        fcs_sel         = 2'(k - int'(n_last));
        fin_d[8*k +: 8] = fcs[8*fcs_sel +: 8];
      end
`endif
      else if (k == int'(term_pos)) begin
        fin_d[8*k +: 8] = CH_TERM;
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge usrclk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      xgmii_txd   <= IDLE_WORD;
      xgmii_txc   <= 8'hFF;
      tx_underrun <= 1'b0;
      frame_count <= 32'd0;
      ifg_cnt     <= 4'd0;
      tail_d      <= IDLE_WORD;
      tail_c      <= 8'hFF;
`ifdef XGMII_TX_FCS_EN
      crc_q       <= CRC_INIT;
`endif
    end else begin
      tx_underrun <= 1'b0;
      case (state)
        // The preamble word is issued on the IDLE exit so the first payload
        // word is accepted while Start is on the wire.
        S_IDLE, S_PREAMBLE: begin
          if (tx_valid || state == S_PREAMBLE) begin
            xgmii_txd <= START_WORD;
            xgmii_txc <= 8'h01;
            state     <= S_DATA;
`ifdef XGMII_TX_FCS_EN
            crc_q     <= CRC_INIT;
`endif
          end else begin
            xgmii_txd <= IDLE_WORD;
            xgmii_txc <= 8'hFF;
          end
        end
        S_DATA: begin
          if (!tx_valid) begin
            xgmii_txd   <= ERROR_WORD;
            xgmii_txc   <= 8'hFF;
            tx_underrun <= 1'b1;
            state       <= S_DROP;
          end else if (tx_last) begin
            xgmii_txd <= fin_d[63:0];
            xgmii_txc <= fin_c[7:0];
            tail_d    <= fin_d[127:64];
            tail_c    <= fin_c[15:8];
            if (term_pos < 5'd8) begin
              frame_count <= frame_count + 32'd1;
              ifg_cnt     <= 4'(IFG_WORDS - 1);
              state       <= S_IFG;
            end else begin
              state <= S_TAIL;
            end
          end else begin
            xgmii_txd <= tx_data;
            xgmii_txc <= 8'h00;
          end
`ifdef XGMII_TX_FCS_EN
          if (tx_valid) crc_q <= crc_next;
`endif
        end
        S_TAIL: begin
          xgmii_txd   <= tail_d;
          xgmii_txc   <= tail_c;
          frame_count <= frame_count + 32'd1;
          ifg_cnt     <= 4'(IFG_WORDS - 1);
          state       <= S_IFG;
        end
        S_DROP: begin
          xgmii_txd <= ERROR_WORD;
          xgmii_txc <= 8'hFF;
          if (tx_valid && tx_last) begin
            ifg_cnt <= 4'(IFG_WORDS - 1);
            state   <= S_IFG;
          end
        end
        S_IFG: begin
          xgmii_txd <= IDLE_WORD;
          xgmii_txc <= 8'hFF;
          if (ifg_cnt == 4'd0) state <= S_IDLE;
          else ifg_cnt <= ifg_cnt - 4'd1;
        end
        default: begin
          xgmii_txd <= IDLE_WORD;
          xgmii_txc <= 8'hFF;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Scoreboard bench for xgmii_tx_framer: expected XGMII words are queued as
// packets are driven and compared as non-Idle words appear on the outputs.
module tb_xgmii_tx_framer;
  import xgmii_pkg::*;

  localparam int IFG = 2;

  logic        usrclk = 1'b0;
  logic        reset  = 1'b1;
  logic [63:0] tx_data  = '0;
  logic        tx_valid = 1'b0;
  logic        tx_last  = 1'b0;
  logic [2:0]  tx_bytes = '0;
  logic        tx_ready;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        tx_underrun;
  logic [31:0] frame_count;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [71:0] exp_q[$];
  logic [7:0]  pkt[$];
  bit         mon_en = 1'b0;
  bit         in_gap = 1'b0;
  int         gap_run = 0;
  int         last_gap = -1;
  int         underrun_cnt = 0;
  int         exp_fc = 0;

  xgmii_tx_framer #(.IFG_WORDS(IFG)) dut (
    .usrclk      (usrclk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_bytes    (tx_bytes),
    .tx_ready    (tx_ready),
    .xgmii_txd   (xgmii_txd),
    .xgmii_txc   (xgmii_txc),
    .tx_underrun (tx_underrun),
    .frame_count (frame_count)
  );

  always #5 usrclk = ~usrclk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Standard byte-at-a-time reflected CRC-32 over the current packet.
  function automatic logic [31:0] model_fcs();
    logic [31:0] crc = 32'hFFFFFFFF;
    foreach (pkt[i]) begin
      crc = crc ^ {24'h0, pkt[i]};
      for (int b = 0; b < 8; b++)
        crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    return ~crc;
  endfunction

  function automatic logic [63:0] pack_word(input int w);
    logic [63:0] d;
    for (int k = 0; k < 8; k++)
      d[8*k +: 8] = (8*w + k < pkt.size()) ? pkt[8*w + k] : 8'hA5;
    return d;
  endfunction

  function automatic bit has_term(input logic [63:0] d, input logic [7:0] c);
    for (int k = 0; k < 8; k++)
      if (c[k] && d[8*k +: 8] == CH_TERM) return 1'b1;
    return 1'b0;
  endfunction

  // Expected frame as a byte stream: payload, FCS, Terminate, Idle padding.
  task automatic push_expected();
    logic [7:0]  s[$];
    logic        c[$];
    logic [63:0] d;
    logic [7:0]  cc;
`ifdef XGMII_TX_FCS_EN
    logic [31:0] f;
`endif
    exp_q.push_back({8'h01, START_WORD});
    foreach (pkt[i]) begin s.push_back(pkt[i]); c.push_back(1'b0); end
`ifdef XGMII_TX_FCS_EN
    f = model_fcs();
    for (int i = 0; i < 4; i++) begin s.push_back(f[8*i +: 8]); c.push_back(1'b0); end
`endif
    s.push_back(8'hFD); c.push_back(1'b1);
    while (s.size() % 8 != 0) begin s.push_back(8'h07); c.push_back(1'b1); end
    for (int w = 0; w < s.size() / 8; w++) begin
      for (int k = 0; k < 8; k++) begin
        d[8*k +: 8] = s[8*w + k];
        cc[k]       = c[8*w + k];
      end
      exp_q.push_back({cc, d});
    end
  endtask

  task automatic make_pkt(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge usrclk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 72'd0, 72'd1);
    else begin @(posedge usrclk); #1; end
  endtask

  task automatic send_packet(input int gap_at, input bit hold);
    int nw = (pkt.size() + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      if (w == gap_at) begin
        tx_valid = 1'b0;
        @(posedge usrclk); #1;
      end
      tx_data  = pack_word(w);
      tx_valid = 1'b1;
      tx_last  = (w == nw - 1);
      tx_bytes = 3'(pkt.size() % 8);
      wait_accept();
    end
    if (!hold) begin tx_valid = 1'b0; tx_last = 1'b0; end
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge usrclk);
    repeat (IFG + 4) @(negedge usrclk);
    check(tag, 72'(exp_q.size()), 72'd0);
  endtask

  always @(negedge usrclk) begin
    if (!reset) begin
      if (tx_underrun) underrun_cnt++;
      if (xgmii_txc == 8'hFF && xgmii_txd == IDLE_WORD) begin
        if (in_gap) gap_run++;
      end else begin
        if (xgmii_txc == 8'h01 && xgmii_txd == START_WORD && in_gap) begin
          last_gap = gap_run;
          in_gap   = 1'b0;
        end
        if (has_term(xgmii_txd, xgmii_txc)) begin
          in_gap  = 1'b1;
          gap_run = 0;
        end
        if (mon_en) begin
          if (exp_q.size() == 0) check("unexpected_word", {xgmii_txc, xgmii_txd}, {8'hFF, IDLE_WORD});
          else check("xgmii_word", {xgmii_txc, xgmii_txd}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge usrclk); #1;
    check("rst_txd", 72'(xgmii_txd), 72'(IDLE_WORD));
    check("rst_txc", 72'(xgmii_txc), 72'hFF);
    check("rst_underrun", 72'(tx_underrun), 72'd0);
    check("rst_frame_count", 72'(frame_count), 72'd0);
    check("rst_ready", 72'(tx_ready), 72'd0);
    repeat (2) @(posedge usrclk);
    @(negedge usrclk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Four full words, tx_bytes = 0.
    make_pkt(32);
    push_expected();
    send_packet(-1, 1'b0);
    drain("drain_four_word");
    exp_fc++;
    check("fc_four_word", 72'(frame_count), 72'(exp_fc));

    // "123456789" with explicitly derived final word.
    pkt.delete();
    for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
    exp_q.push_back({8'h01, START_WORD});
    exp_q.push_back({8'h00, 64'h3837363534333231});
`ifdef XGMII_TX_FCS_EN
    exp_q.push_back({8'hE0, 64'h0707FDCBF4392639});
`else
    exp_q.push_back({8'hFE, 64'h070707070707FD39});
`endif
    send_packet(-1, 1'b0);
    drain("drain_check_string");
    exp_fc++;
    check("fc_check_string", 72'(frame_count), 72'(exp_fc));

    // Back-to-back packets with tx_valid held high.
    last_gap = -1;
    make_pkt(20);
    push_expected();
    send_packet(-1, 1'b1);
    make_pkt(13);
    push_expected();
    send_packet(-1, 1'b0);
    drain("drain_back_to_back");
    check("ifg_back_to_back", 72'(last_gap), 72'(IFG));
    exp_fc += 2;
    check("fc_back_to_back", 72'(frame_count), 72'(exp_fc));

    // Underrun after two words of a six-word packet.
    underrun_cnt = 0;
    make_pkt(48);
    exp_q.push_back({8'h01, START_WORD});
    exp_q.push_back({8'h00, pack_word(0)});
    exp_q.push_back({8'h00, pack_word(1)});
    for (int i = 0; i < 5; i++) exp_q.push_back({8'hFF, ERROR_WORD});
    send_packet(2, 1'b0);
    drain("drain_underrun");
    check("underrun_pulses", 72'(underrun_cnt), 72'd1);
    check("fc_underrun", 72'(frame_count), 72'(exp_fc));

    // Final word with six valid bytes, then a spread of lengths.
    make_pkt(14);
    push_expected();
    send_packet(-1, 1'b0);
    drain("drain_six_byte_tail");
    exp_fc++;
    for (int p = 0; p < 8; p++) begin
      make_pkt((p < 4) ? 4 + p : $urandom_range(1, 24));
      push_expected();
      send_packet(-1, 1'b0);
      drain("drain_length_sweep");
      exp_fc++;
    end
    check("fc_length_sweep", 72'(frame_count), 72'(exp_fc));

    // Reset while in DATA.
    mon_en = 1'b0;
    make_pkt(32);
    tx_data  = pack_word(0);
    tx_valid = 1'b1;
    tx_last  = 1'b0;
    wait_accept();
    tx_data = pack_word(1);
    wait_accept();
    tx_data = pack_word(2);
    @(negedge usrclk);
    reset = 1'b1;
    @(posedge usrclk); #1;
    check("midreset_txd", 72'(xgmii_txd), 72'(IDLE_WORD));
    check("midreset_txc", 72'(xgmii_txc), 72'hFF);
    check("midreset_ready", 72'(tx_ready), 72'd0);
    check("midreset_fc", 72'(frame_count), 72'd0);
    tx_valid = 1'b0;
    @(negedge usrclk);
    reset = 1'b0;
    exp_q.delete();
    exp_fc = 0;
    mon_en = 1'b1;

    make_pkt(11);
    push_expected();
    send_packet(-1, 1'b0);
    drain("drain_after_reset");
    exp_fc++;
    check("fc_after_reset", 72'(frame_count), 72'(exp_fc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
